i2s_tx: RTL
===========

# i2s_tx

Serial audio transmitter at the output end of the channel strip. It takes parallel 16-bit left/right samples from the filter chain (e.g. lowpass output) and serialises them to a codec DAC in I2S format. It generates BCLK and LRCLK from the system clock and emits a one-cycle `sample_tick` per frame, which the filter chain uses as its sample-rate enable.

## Interface
Parameters:
- `DATA_W`, 16: sample width, two's complement.
- `SLOT_W`, 32: BCLK periods per channel slot. Constraint: `SLOT_W >= DATA_W+1`.
- `BCLK_HALF`, 4: clk cycles per BCLK half-period; must be ≥1. Frame = 2·SLOT_W·2·BCLK_HALF clk; defaults give 512 clk, i.e. 48 kHz at 24.576 MHz.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `left_in`  in  DATA_W  left sample.
- `right_in`  in  DATA_W  right sample.
- `in_valid`  in  1  one-cycle strobe; captures left_in/right_in into the holding register.
- `sample_tick`  out  1  one-clk pulse per frame; the holding register was just consumed.
- `underrun`  out  1  one-clk pulse; frame started with no new sample.
- `overrun`  out  1  one-clk pulse; in_valid while the holding register was already full.
- `bclk`  out  1  bit clock.
- `lrclk`  out  1  word select: 0 = left, 1 = right.
- `sdata`  out  1  serial data.

## Operation
- Divider: `div_cnt` runs 0..BCLK_HALF-1. When it reaches BCLK_HALF-1, it wraps to 0 and `bclk` toggles. A toggle from 1→0 is a *fall event*.
- Bit counter: `bit_cnt` runs 0..2·SLOT_W-1 and advances on each fall event, wrapping to 0. `lrclk` = (new bit_cnt ≥ SLOT_W) and is updated on the fall event.
- sdata on a fall event into bit_cnt b:
  - p = b mod SLOT_W; channel = right if b ≥ SLOT_W, else left (from the frame registers).
  - sdata = ch[DATA_W-p] for 1 ≤ p ≤ DATA_W, otherwise 0.
  - Result: MSB appears one BCLK after the LRCLK edge, MSB first, zero padded.
- Holding register:
  - in_valid writes {left_in, right_in} and sets `hold_valid`. Latest write wins.
  - If hold_valid was already 1 and no frame load occurs in the same cycle, pulse overrun.
- Frame start (fall event with bit_cnt wrapping to 0):
  - If hold_valid: load the frame registers from the holding register, clear hold_valid.
  - Else: reload the frame registers from the holding register (the previous sample repeats) and pulse underrun.
  - sample_tick pulses in both cases.
- Simultaneous in_valid and frame start: the frame loads the old holding contents. The new data is written to holding, hold_valid ends at 1, and no overrun is flagged.
- Reset (asynchronous, any time, including mid-frame):
  - All counters, holding/frame registers, hold_valid, bclk, lrclk, sdata, sample_tick, underrun and overrun go to 0.
  - On release, operation restarts from bit_cnt 0. The first frame after reset transmits zeros and does not pulse sample_tick.

## Timing
- All outputs are registered; none is combinational from inputs.
- After reset release (count rising clk edges from 1):
  - bclk rises at edge BCLK_HALF and falls at 2·BCLK_HALF.
  - The first frame start is at edge 2·SLOT_W·2·BCLK_HALF (512 with defaults).
- sample_tick, underrun and overrun are high exactly one clk cycle, registered on the same edge as the frame-start fall event or the in_valid edge.
- sdata and lrclk change only on clk edges where bclk falls; they are stable across every bclk rising edge.
- Latency: a sample accepted at any edge before frame start N is transmitted in frame N. Its left MSB appears 2·BCLK_HALF clk after frame start; its right MSB appears (SLOT_W+1)·2·BCLK_HALF clk after frame start.
- sample_tick period = frame period, constant. Minimum in_valid spacing for loss-free operation = 1 per frame.

## Test plan
- Reset: hold reset_n=0 → every output is 0. Release → bclk period 8 clk, lrclk period 512 clk, first sample_tick at clk edge 512, sdata all 0 in the first frame.
- Data: after first tick, in_valid with left=0x7FFF, right=0x8000 → next frame:
  - left slot bits p1..p16 = 0,1×15; right slot p1..p16 = 1,0×15.
  - Padding 0; sdata stable at every bclk rise; one sample_tick; no flags.
- Underrun: no in_valid for one frame after loading 0x1234/0xABCD → underrun pulses with that frame's sample_tick, and 0x1234/0xABCD repeat on sdata.
- Overrun: two in_valid (0x0001 then 0x0002) within one frame → overrun pulse on the second; next frame transmits left 0x0002.
- Boundary: in_valid with 0x5555 on the exact frame-start edge → the frame sends the previous holding value, 0x5555 goes in the following frame, no overrun, no underrun.
- Mid-frame reset: assert reset_n=0 at bit_cnt 20 → outputs 0 immediately (asynchronously). After release, timing matches the reset scenario and the old sample is not transmitted.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: I2S serialiser with BCLK/LRCLK generation,
// a single-sample holding register and a frame-rate tick.
module i2s_tx #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              in_valid,
  output logic              sample_tick,
  output logic              underrun,
  output logic              overrun,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata
);

  localparam int DIV_W = $clog2(BCLK_HALF + 1);
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic              r_bclk;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_tick;
  logic              r_under;
  logic              r_over;
  logic              r_hold_v;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_frm_l;
  logic [DATA_W-1:0] r_frm_r;

  logic              w_div_wrap;
  logic              w_fall;
  logic              w_last;
  logic              w_fstart;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic              w_right;
  logic [BIT_W-1:0]  w_p;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_ch;
  logic              w_sd;

  assign w_div_wrap = (r_div == DIV_W'(BCLK_HALF - 1));
  assign w_fall     = w_div_wrap & r_bclk;
  assign w_last     = (r_bit == BIT_W'(2 * SLOT_W - 1));
  assign w_fstart   = w_fall & w_last;
  assign w_bit_nxt  = w_last ? '0 : r_bit + BIT_W'(1);
  assign w_right    = (w_bit_nxt >= BIT_W'(SLOT_W));
  assign w_p        = w_right ? w_bit_nxt - BIT_W'(SLOT_W)
                              : w_bit_nxt;
  assign w_idx      = IDX_W'(BIT_W'(DATA_W) - w_p);

  // Slot position 0 is the I2S one-bit delay; data then MSB first.
  always_comb begin
    w_ch = w_right ? r_frm_r : r_frm_l;
    w_sd = 1'b0;
    if (w_p >= BIT_W'(1) && w_p <= BIT_W'(DATA_W))
      w_sd = w_ch[w_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
      if (w_div_wrap)
        r_bclk <= ~r_bclk;
      if (w_fall) begin
        r_bit   <= w_bit_nxt;
        r_lrclk <= w_right;
        r_sdata <= w_sd;
      end
    end
  end

  // Frame start always reloads from holding, so an
  // empty holding register repeats the previous sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_v <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_frm_l  <= '0;
      r_frm_r  <= '0;
      r_tick   <= 1'b0;
      r_under  <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      if (w_fstart) begin
        r_frm_l <= r_hold_l;
        r_frm_r <= r_hold_r;
      end
      if (in_valid) begin
        r_hold_l <= left_in;
        r_hold_r <= right_in;
      end
      r_hold_v <= in_valid | (r_hold_v & ~w_fstart);
      r_tick   <= w_fstart;
      r_under  <= w_fstart & ~r_hold_v;
      r_over   <= in_valid & r_hold_v & ~w_fstart;
    end
  end

  assign bclk        = r_bclk;
  assign lrclk       = r_lrclk;
  assign sdata       = r_sdata;
  assign sample_tick = r_tick;
  assign underrun    = r_under;
  assign overrun     = r_over;

endmodule
